// File: rtl/dmem_responder.sv
// dmem_responder: in-order data-memory responder with a small request queue in
// front of a byte-writable word array. Optional address range check: DMEM_RESPONDER_RANGE_CHECK_EN.
module dmem_responder #(
    parameter int          ADDR_BITS = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int          LATENCY   = 2,
    parameter int          DEPTH     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_fence,
    input  logic        mem_spec,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_error,
    output logic        overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WORDS = 1 << ADDR_BITS;
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [3:0]       RELOAD_NEW = 4'(LATENCY - 1);
    // Back-to-back entries reload one less so the RESP cycle counts toward the
    // next entry's latency, giving one response every LATENCY cycles.
    localparam logic [3:0]       RELOAD_B2B = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             resp_load_q, resp_load_d;

    logic             q_fence_q [DEPTH];
    logic [29:0]      q_word_q  [DEPTH];
    logic [31:0]      q_wdata_q [DEPTH];
    logic [3:0]       q_wstrb_q [DEPTH];

    logic             full;
    logic             deq;
    logic             accept;
    logic             enter;
    logic [PTR_W-1:0] acc_ptr;
    logic             acc_fence;
    logic [29:0]      acc_word;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_wstrb;
    logic [ADDR_BITS-1:0] acc_idx;
    logic             in_range;
    logic [3:0]       wr_en;
    logic             rd_en;
    logic [31:0]      rd_word;

    assign full   = (count_q == FULL_CNT);
    assign deq    = (state_q == RESP);
    assign accept = mem_valid && (!full || deq);

    assign count_d  = count_q + CNT_W'(accept) - CNT_W'(deq);
    assign wr_ptr_d = wr_ptr_q + PTR_W'(accept);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(deq);
    assign ovf_d    = ovf_q || (mem_valid && full && !deq);

    always_ff @(posedge clock) begin
        if (accept) begin
            q_fence_q[wr_ptr_q] <= mem_fence;
            q_word_q[wr_ptr_q]  <= mem_addr[31:2];
            q_wdata_q[wr_ptr_q] <= mem_wdata;
            q_wstrb_q[wr_ptr_q] <= mem_wstrb;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = RELOAD_NEW;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // Entries already queued behind the head keep the steady cadence;
                // one arriving only now is timed from its own arrival.
                if (count_q > CNT_W'(1)) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = RELOAD_B2B;
                    end
                end else if (accept) begin
                    state_d = WAIT;
                    cnt_d   = RELOAD_NEW;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            resp_load_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            resp_load_q <= resp_load_d;
        end
    end

    // The array access happens on the edge entering RESP; when RESP repeats the
    // current head is being popped on that same edge, so the next entry is used.
    assign enter     = (state_d == RESP) && !reset;
    assign acc_ptr   = (state_q == RESP) ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    assign acc_fence = q_fence_q[acc_ptr];
    assign acc_word  = q_word_q[acc_ptr];
    assign acc_wdata = q_wdata_q[acc_ptr];
    assign acc_wstrb = q_wstrb_q[acc_ptr];
    assign acc_idx   = acc_word[ADDR_BITS-1:0];

    assign rd_en       = enter && !acc_fence && in_range && (acc_wstrb == 4'd0);
    assign resp_load_d = rd_en;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [WORDS];
            logic [7:0] lane_rd_q;

            assign wr_en[gi] = enter && !acc_fence && in_range && acc_wstrb[gi];

            always_ff @(posedge clock) begin
                if (wr_en[gi]) begin
                    lane_mem[acc_idx] <= acc_wdata[8*gi +: 8];
                end
                if (rd_en) begin
                    lane_rd_q <= lane_mem[acc_idx];
                end
            end

            assign rd_word[8*gi +: 8] = lane_rd_q;
        end
    endgenerate

    assign mem_ready = (state_q == RESP);
    assign mem_rdata = (mem_ready && resp_load_q) ? rd_word : 32'd0;
    assign overflow  = ovf_q;

`ifdef DMEM_RESPONDER_RANGE_CHECK_EN
    logic resp_err_q;
    logic resp_err_d;
    logic unused_ok;

    assign in_range   = (acc_word[29:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS+2]);
    assign resp_err_d = enter && !acc_fence && !in_range;

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_err_q <= 1'b0;
        end else begin
            resp_err_q <= resp_err_d;
        end
    end

    assign mem_error = mem_ready && resp_err_q;
    assign unused_ok = &{1'b0, mem_spec, mem_instr, mem_addr[1:0]};
`else
    logic unused_ok;

    // Upper address bits are don't-care: the array aliases across the space.
    assign in_range  = 1'b1;
    assign mem_error = 1'b0;
    assign unused_ok = &{1'b0, mem_spec, mem_instr, mem_addr[1:0], acc_word[29:ADDR_BITS]};
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the core's data-side memory interface.
- Receives the request bundle the decode stage drives: valid, fence, spec, instr, addr, wdata, wstrb.
- Returns read data, ready and error, in order, after a fixed access latency.
- Backs the requests with an internal byte-writable word array.
- Contains a small in-order request queue, so the pipeline can issue back-to-back loads and stores without a handshake stall.

Parameters:
- ADDR_BITS, 12, log2 of the number of 32-bit words in the array (4096 words, 16 KiB).
- BASE_ADDR, 32'h0001_0000, byte address of word 0; must be aligned to 4*2**ADDR_BITS.
- LATENCY, 2, cycles from a request reaching the queue head to its response; legal range 1..15.
- DEPTH, 4, request queue entries; must be a power of two and at least 2.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  request strobe; one request per cycle it is high.
- mem_fence  in  1  request is a fence (address and data are ignored).
- mem_spec  in  1  speculative hint; ignored.
- mem_instr  in  1  instruction-fetch tag; ignored.
- mem_addr  in  32  byte address; bits [1:0] are ignored.
- mem_wdata  in  32  store data, already lane-aligned.
- mem_wstrb  in  4  byte enables; 0 means load, nonzero means store.
- mem_rdata  out  32  load data; 0 for stores, fences and errors.
- mem_ready  out  1  one-cycle response strobe, in request order.
- mem_error  out  1  access fault; valid while mem_ready=1.
- overflow  out  1  sticky flag: a request was dropped because the queue was full.

Behaviour:
- Reset is synchronous and active-high.
  - Clears the queue pointers, count, latency counter and overflow.
  - mem_ready=0, mem_error=0, mem_rdata=0.
  - Array contents are not reset and are retained across reset.
  - Any request in flight when reset asserts is discarded; no response is produced for it.
- Enqueue: on a rising edge with mem_valid=1, store {fence, addr[31:2], wdata, wstrb} at the write pointer.
  - The write pointer wraps modulo DEPTH.
- Queue full (count==DEPTH) with no dequeue that cycle: the request is dropped and overflow sets to 1.
  - overflow clears only on reset.
- Queue full with a dequeue in the same cycle: the request is accepted and count stays unchanged.
- FSM states:
  - IDLE: queue empty.
  - WAIT: head entry present, latency counter running.
  - RESP: head entry completes.
- IDLE -> WAIT: on the edge where count becomes nonzero; the counter loads LATENCY-1.
- WAIT: the counter decrements each cycle; at 0, go to RESP.
- RESP, one cycle:
  - Perform the array access for the head entry.
  - Drive mem_ready=1 with mem_rdata and mem_error for that entry.
  - Pop the head entry.
  - If more entries remain, go to WAIT and reload the counter; otherwise go to IDLE.
- Timing: with an empty queue, a request sampled at edge T produces mem_ready high in cycle T+LATENCY.
  - Sustained throughput is one response per LATENCY cycles.
- Load: mem_rdata = array[word index] registered as a full 32-bit word.
  - Byte and halfword extraction is done by the consumer.
- Store: for each i, if wstrb[i]=1 write byte i; mem_rdata=0.
- Fence: no array access; mem_ready=1, mem_rdata=0, mem_error=0.
  - Because processing is in order, a fence response implies all earlier stores are complete.
- Word index = addr[ADDR_BITS+1:2].
- Ordering: processing is strictly in order, so a load always observes every earlier store, including back-to-back same-address pairs.
- mem_ready is never high for two consecutive cycles when LATENCY>1.

Optional Feature:
- Macro: DMEM_RESPONDER_RANGE_CHECK_EN.
- Defined:
  - A non-fence request whose addr[31:ADDR_BITS+2] differs from BASE_ADDR[31:ADDR_BITS+2] gets mem_error=1 on its response.
  - No write occurs and mem_rdata=0 for that request.
- Undefined:
  - Upper address bits are ignored, so addresses alias modulo the array size.
  - mem_error is tied to 0.

Test Plan:
- Single load/store, LATENCY=2:
  - Store 0xDEADBEEF, wstrb=4'hF to 0x0001_0010 at edge T -> mem_ready=1 in cycle T+2, mem_rdata=0.
  - Load of 0x0001_0010 issued at T+3 -> mem_ready at T+5 with mem_rdata=0xDEADBEEF.
- Byte strobes:
  - Store 0x000000AA, wstrb=4'h1 to 0x0001_0010 (after the above).
  - Load of the same address -> 0xDEADBEAA.
  - Store 0x55000000, wstrb=4'h8, then load -> 0x55ADBEAA.
- Back-to-back and full queue, DEPTH=4, LATENCY=2:
  - Issue 6 consecutive loads.
  - -> The first 4 are accepted; the 5th is accepted only if a dequeue coincides that cycle; otherwise overflow=1.
  - Accepted loads respond in order, one every 2 cycles.
- Fence ordering:
  - Store 0x12345678 to 0x0001_0020, then a fence, then a load of 0x0001_0020, all consecutive.
  - -> Responses in order: store (rdata 0), fence (rdata 0), load (0x12345678).
- Reset mid-operation:
  - Enqueue 3 loads, assert reset for 1 cycle after the first response.
  - -> No further mem_ready; overflow=0; array data written before reset is still readable afterwards.
- Range check:
  - Load of 0x0002_0000 with the macro defined -> mem_ready with mem_error=1, rdata=0.
  - Same load without the macro -> mem_error=0, data from word 0.
